// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package rf_arb_pkg;

    localparam int RF_DW   = 32;
    localparam int RF_AW   = 5;
    localparam int RF_NREG = 32;

    // Register-file write-enable encodings.
    localparam logic [1:0] RFWE_WRITE = 2'b01;
    localparam logic [1:0] RFWE_IDLE  = 2'b00;

    // Writeback source index; also the round-robin pointer value.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_M = 1'b1
    } port_e;

    // One holding entry. young marks an entry captured while the other
    // port already held an older, un-granted request.
    typedef struct packed {
        logic             full;
        logic             young;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } hold_t;

    // One-hot register bit, gated by en.
    function automatic logic [RF_NREG-1:0] reg_bit(input logic en,
                                                   input logic [RF_AW-1:0] addr);
        logic [RF_NREG-1:0] v;
        v = '0;
        if (en) v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding register with valid/ready capture and age bit.
// Latency: request visible in the entry one edge after acceptance.
// Backpressure: ready = empty, or the entry is leaving this cycle; never depends on valid.
//   ZERO_REG_GUARD_EN: entries for register 0 are accepted and then discarded.
module rf_wb_slot
    import rf_arb_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_vld,
    input  logic [RF_AW-1:0] req_addr,
    input  logic [RF_DW-1:0] req_dat,
    output logic             req_rdy,
    input  logic             grant,
    input  logic             other_full,
    input  logic             other_clr,
    output hold_t            ent,
    output logic             drop
);

    logic load;

    // Register-0 writes are silently retired one cycle after capture.
`ifdef ZERO_REG_GUARD_EN
    assign drop = ent.full && (ent.addr == '0);
`else
    assign drop = 1'b0;
`endif

    // The entry frees up on the same edge it is granted or dropped, so a
    // streaming source keeps one request per cycle.
    assign req_rdy = ~ent.full | grant | drop;
    assign load    = req_vld & req_rdy;

    // Capture, retire, and age tracking relative to the other port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ent <= '0;
        end else if (load) begin
            ent.full  <= 1'b1;
            // Younger only if the other entry stays behind after this edge.
            ent.young <= other_full & ~other_clr;
            ent.addr  <= req_addr;
            ent.data  <= req_dat;
        end else if (grant | drop) begin
            ent.full  <= 1'b0;
            ent.young <= 1'b0;
        end else if (other_clr) begin
            // The older entry has left; this one is now the oldest.
            ent.young <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-source writeback arbiter driving the single register-file write port.
// Latency: accept at edge N, registered RFWE/RFWA/RFWD valid after edge N+1; +1 cycle per earlier contested grant.
// Backpressure: ARDY/MRDY follow each slot's occupancy and this cycle's grant only.
//   ZERO_REG_GUARD_EN: register-0 requests are accepted but never written.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               AV,
    input  logic [AW-1:0]      AA,
    input  logic [DW-1:0]      AD,
    output logic               ARDY,
    input  logic               MV,
    input  logic [AW-1:0]      MA,
    input  logic [DW-1:0]      MD,
    output logic               MRDY,
    output logic [1:0]         RFWE,
    output logic [AW-1:0]      RFWA,
    output logic [DW-1:0]      RFWD,
    output logic [RF_NREG-1:0] PEND
);

    hold_t ea;
    hold_t em;
    logic  a_drop;
    logic  m_drop;
    logic  a_elig;
    logic  m_elig;
    logic  gnt_a;
    logic  gnt_m;
    logic  rr_contest;
    port_e rr;

    rf_wb_slot u_slot_a (
        .CLK        (CLK),
        .RST        (RST),
        .req_vld    (AV),
        .req_addr   (AA),
        .req_dat    (AD),
        .req_rdy    (ARDY),
        .grant      (gnt_a),
        .other_full (em.full),
        .other_clr  (gnt_m | m_drop),
        .ent        (ea),
        .drop       (a_drop)
    );

    rf_wb_slot u_slot_m (
        .CLK        (CLK),
        .RST        (RST),
        .req_vld    (MV),
        .req_addr   (MA),
        .req_dat    (MD),
        .req_rdy    (MRDY),
        .grant      (gnt_m),
        .other_full (ea.full),
        .other_clr  (gnt_a | a_drop),
        .ent        (em),
        .drop       (m_drop)
    );

    // An entry being discarded this cycle never competes for the port.
    assign a_elig = ea.full & ~a_drop;
    assign m_elig = em.full & ~m_drop;

    // Grant selection: same-register conflicts resolve by age (A on a tie),
    // different-register conflicts by the round-robin pointer.
    always_comb begin
        gnt_a      = 1'b0;
        gnt_m      = 1'b0;
        rr_contest = 1'b0;
        if (a_elig && m_elig) begin
            if (ea.addr == em.addr) begin
                if (ea.young && !em.young) gnt_m = 1'b1;
                else                       gnt_a = 1'b1;
            end else begin
                rr_contest = 1'b1;
                if (rr == PORT_A) gnt_a = 1'b1;
                else              gnt_m = 1'b1;
            end
        end else if (a_elig) begin
            gnt_a = 1'b1;
        end else if (m_elig) begin
            gnt_m = 1'b1;
        end
    end

    // Round-robin pointer moves to the loser of a different-register contest.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr <= PORT_A;
        end else if (rr_contest) begin
            rr <= gnt_a ? PORT_M : PORT_A;
        end
    end

    // Registered write port; address/data hold while idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RFWE <= RFWE_IDLE;
            RFWA <= '0;
            RFWD <= '0;
        end else if (gnt_a) begin
            RFWE <= RFWE_WRITE;
            RFWA <= ea.addr;
            RFWD <= ea.data;
        end else if (gnt_m) begin
            RFWE <= RFWE_WRITE;
            RFWA <= em.addr;
            RFWD <= em.data;
        end else begin
            RFWE <= RFWE_IDLE;
        end
    end

    // Pending bitmap: both holding entries plus the write in flight.
    always_comb begin
        PEND = reg_bit(a_elig, ea.addr)
             | reg_bit(m_elig, em.addr)
             | reg_bit(RFWE == RFWE_WRITE, RFWA);
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic        CLK;
    logic        RST;
    logic        AV;
    logic [4:0]  AA;
    logic [31:0] AD;
    logic        ARDY;
    logic        MV;
    logic [4:0]  MA;
    logic [31:0] MD;
    logic        MRDY;
    logic [1:0]  RFWE;
    logic [4:0]  RFWA;
    logic [31:0] RFWD;
    logic [31:0] PEND;

    int vec;
    int errs;
    logic [36:0] wlog[$];

    rf_write_arbiter dut (
        .CLK  (CLK),
        .RST  (RST),
        .AV   (AV),
        .AA   (AA),
        .AD   (AD),
        .ARDY (ARDY),
        .MV   (MV),
        .MA   (MA),
        .MD   (MD),
        .MRDY (MRDY),
        .RFWE (RFWE),
        .RFWA (RFWA),
        .RFWD (RFWD),
        .PEND (PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Every write the register file would perform, in order.
    always @(posedge CLK) begin
        if (!RST && RFWE == 2'b01) wlog.push_back({RFWA, RFWD});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        AV = 1'b0; MV = 1'b0;
        AA = '0; AD = '0; MA = '0; MD = '0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        wlog.delete();
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (ARDY !== 1'b1) begin errs++; $display("FAIL reset_ardy got %b want 1", ARDY); end
        vec++; if (MRDY !== 1'b1) begin errs++; $display("FAIL reset_mrdy got %b want 1", MRDY); end
        vec++; if (RFWE !== 2'b00) begin errs++; $display("FAIL reset_rfwe got %b want 00", RFWE); end
        vec++; if (RFWA !== 5'd0) begin errs++; $display("FAIL reset_rfwa got %0d want 0", RFWA); end
        vec++; if (RFWD !== 32'd0) begin errs++; $display("FAIL reset_rfwd got %h want 0", RFWD); end
        vec++; if (PEND !== 32'd0) begin errs++; $display("FAIL reset_pend got %h want 0", PEND); end
    endtask

    task automatic test_single();
        do_reset();
        AV = 1'b1; AA = 5'd5; AD = 32'hDEAD_BEEF;
        tick();                                 // edge 1: accepted
        AV = 1'b0;
        vec++; if (RFWE !== 2'b00) begin errs++; $display("FAIL single_e1_rfwe got %b want 00", RFWE); end
        vec++; if (PEND !== 32'h0000_0020) begin errs++; $display("FAIL single_e1_pend got %h want 00000020", PEND); end
        tick();                                 // edge 2: written to port
        vec++; if (RFWE !== 2'b01) begin errs++; $display("FAIL single_e2_rfwe got %b want 01", RFWE); end
        vec++; if (RFWA !== 5'd5) begin errs++; $display("FAIL single_e2_rfwa got %0d want 5", RFWA); end
        vec++; if (RFWD !== 32'hDEAD_BEEF) begin errs++; $display("FAIL single_e2_rfwd got %h want deadbeef", RFWD); end
        vec++; if (PEND !== 32'h0000_0020) begin errs++; $display("FAIL single_e2_pend got %h want 00000020", PEND); end
        tick();                                 // edge 3: idle, address holds
        vec++; if (RFWE !== 2'b00) begin errs++; $display("FAIL single_e3_rfwe got %b want 00", RFWE); end
        vec++; if (RFWA !== 5'd5) begin errs++; $display("FAIL single_e3_rfwa_hold got %0d want 5", RFWA); end
        vec++; if (PEND !== 32'd0) begin errs++; $display("FAIL single_e3_pend got %h want 0", PEND); end
        vec++; if (wlog.size() !== 1) begin errs++; $display("FAIL single_count got %0d want 1", wlog.size()); end
    endtask

    task automatic test_same_edge();
        do_reset();
        AV = 1'b1; AA = 5'd3; AD = 32'h33;
        MV = 1'b1; MA = 5'd7; MD = 32'h77;
        tick();                                 // edge 1: both captured
        AV = 1'b0; MV = 1'b0;
        vec++; if ({ARDY, MRDY} !== 2'b10) begin errs++; $display("FAIL contest_rdy got %b want 10", {ARDY, MRDY}); end
        vec++; if (PEND !== 32'h0000_0088) begin errs++; $display("FAIL contest_e1_pend got %h want 00000088", PEND); end
        tick();
        vec++; if ({RFWE, RFWA, RFWD} !== {2'b01, 5'd3, 32'h33}) begin errs++; $display("FAIL contest_first got %b/%0d/%h want 01/3/33", RFWE, RFWA, RFWD); end
        vec++; if (PEND !== 32'h0000_0088) begin errs++; $display("FAIL contest_e2_pend got %h want 00000088", PEND); end
        tick();
        vec++; if ({RFWE, RFWA, RFWD} !== {2'b01, 5'd7, 32'h77}) begin errs++; $display("FAIL contest_second got %b/%0d/%h want 01/7/77", RFWE, RFWA, RFWD); end
        vec++; if (PEND !== 32'h0000_0080) begin errs++; $display("FAIL contest_e3_pend got %h want 00000080", PEND); end
        tick();
        vec++; if (PEND !== 32'd0) begin errs++; $display("FAIL contest_e4_pend got %h want 0", PEND); end
    endtask

    // Runs straight after test_same_edge: the pointer now prefers M, so a
    // same-register tie must still go to A by age.
    task automatic test_tie_same_addr();
        AV = 1'b1; AA = 5'd8; AD = 32'hA8;
        MV = 1'b1; MA = 5'd8; MD = 32'hB8;
        tick();
        AV = 1'b0; MV = 1'b0;
        tick();
        vec++; if ({RFWA, RFWD} !== {5'd8, 32'hA8}) begin errs++; $display("FAIL tie_first got %0d/%h want 8/a8", RFWA, RFWD); end
        tick();
        vec++; if ({RFWA, RFWD} !== {5'd8, 32'hB8}) begin errs++; $display("FAIL tie_second got %0d/%h want 8/b8", RFWA, RFWD); end
        tick();
    endtask

    task automatic test_same_addr();
        do_reset();
        AV = 1'b1; AA = 5'd9; AD = 32'd1;
        tick();                                 // edge 1: A captured
        AV = 1'b0;
        MV = 1'b1; MA = 5'd9; MD = 32'd2;
        vec++; if (PEND !== 32'h0000_0200) begin errs++; $display("FAIL order_e1_pend got %h want 00000200", PEND); end
        tick();                                 // edge 2: M captured, A written
        MV = 1'b0;
        vec++; if (PEND !== 32'h0000_0200) begin errs++; $display("FAIL order_e2_pend got %h want 00000200", PEND); end
        tick();
        vec++; if (PEND !== 32'h0000_0200) begin errs++; $display("FAIL order_e3_pend got %h want 00000200", PEND); end
        tick();
        vec++; if (PEND !== 32'd0) begin errs++; $display("FAIL order_e4_pend got %h want 0", PEND); end
        vec++; if (wlog.size() !== 2) begin errs++; $display("FAIL order_count got %0d want 2", wlog.size()); end
        else begin
            vec++; if (wlog[0] !== {5'd9, 32'd1}) begin errs++; $display("FAIL order_w0 got %h want %h", wlog[0], {5'd9, 32'd1}); end
            vec++; if (wlog[1] !== {5'd9, 32'd2}) begin errs++; $display("FAIL order_w1_final got %h want %h", wlog[1], {5'd9, 32'd2}); end
        end
    endtask

    task automatic test_back_to_back();
        int a_n;
        int m_n;
        logic a_take;
        logic m_take;
        logic [36:0] exp_w;
        a_n = 0; m_n = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            AV = 1'b1; AA = 5'(10 + a_n); AD = 32'hA000_0000 + 32'(a_n);
            MV = 1'b1; MA = 5'(20 + m_n); MD = 32'hB000_0000 + 32'(m_n);
            if (k == 0) begin
                vec++; if ({ARDY, MRDY} !== 2'b11) begin errs++; $display("FAIL stream_rdy_c0 got %b want 11", {ARDY, MRDY}); end
            end else begin
                vec++; if ({ARDY, MRDY} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL stream_rdy_c%0d got %b want %b", k, {ARDY, MRDY}, (k % 2 == 1) ? 2'b10 : 2'b01); end
            end
            if (k >= 2) begin
                vec++; if (RFWE !== 2'b01) begin errs++; $display("FAIL stream_rfwe_c%0d got %b want 01", k, RFWE); end
            end
            a_take = ARDY;
            m_take = MRDY;
            tick();
            if (a_take) a_n++;
            if (m_take) m_n++;
        end
        AV = 1'b0; MV = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        vec++; if (wlog.size() !== 9) begin errs++; $display("FAIL stream_count got %0d want 9", wlog.size()); end
        else begin
            for (int i = 0; i < 9; i++) begin
                if (i % 2 == 0) exp_w = {5'(10 + i / 2), 32'hA000_0000 + 32'(i / 2)};
                else            exp_w = {5'(20 + i / 2), 32'hB000_0000 + 32'(i / 2)};
                vec++; if (wlog[i] !== exp_w) begin errs++; $display("FAIL stream_w%0d got %h want %h", i, wlog[i], exp_w); end
            end
        end
        vec++; if (PEND !== 32'd0) begin errs++; $display("FAIL stream_drain_pend got %h want 0", PEND); end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        AV = 1'b1; AA = 5'd12; AD = 32'h1212;
        MV = 1'b1; MA = 5'd13; MD = 32'h1313;
        tick();                                 // both slots full
        AV = 1'b0; MV = 1'b0;
        vec++; if (PEND !== 32'h0000_3000) begin errs++; $display("FAIL rstmid_pre_pend got %h want 00003000", PEND); end
        n0 = wlog.size();
        #2 RST = 1'b1;
        #1;
        vec++; if (PEND !== 32'd0) begin errs++; $display("FAIL rstmid_pend got %h want 0", PEND); end
        vec++; if ({ARDY, MRDY} !== 2'b11) begin errs++; $display("FAIL rstmid_rdy got %b want 11", {ARDY, MRDY}); end
        vec++; if ({RFWE, RFWA, RFWD} !== 39'd0) begin errs++; $display("FAIL rstmid_port got %b/%0d/%h want 00/0/0", RFWE, RFWA, RFWD); end
        tick();
        RST = 1'b0;
        tick();
        tick();
        vec++; if (wlog.size() !== n0) begin errs++; $display("FAIL rstmid_nowrite got %0d want %0d", wlog.size(), n0); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        AV = 1'b1; AA = 5'd0; AD = 32'h1234;
        vec++; if (ARDY !== 1'b1) begin errs++; $display("FAIL zero_ardy got %b want 1", ARDY); end
        tick();
        AV = 1'b0;
`ifdef ZERO_REG_GUARD_EN
        vec++; if (PEND !== 32'd0) begin errs++; $display("FAIL zero_e1_pend got %h want 0", PEND); end
        tick();
        vec++; if (RFWE !== 2'b00) begin errs++; $display("FAIL zero_e2_rfwe got %b want 00", RFWE); end
        vec++; if (ARDY !== 1'b1) begin errs++; $display("FAIL zero_e2_ardy got %b want 1", ARDY); end
        tick();
        vec++; if (wlog.size() !== 0) begin errs++; $display("FAIL zero_count got %0d want 0", wlog.size()); end
`else
        vec++; if (PEND !== 32'h0000_0001) begin errs++; $display("FAIL zero_e1_pend got %h want 00000001", PEND); end
        tick();
        vec++; if ({RFWE, RFWA, RFWD} !== {2'b01, 5'd0, 32'h1234}) begin errs++; $display("FAIL zero_write got %b/%0d/%h want 01/0/1234", RFWE, RFWA, RFWD); end
        tick();
        vec++; if (wlog.size() !== 1) begin errs++; $display("FAIL zero_count got %0d want 1", wlog.size()); end
`endif
    endtask

    initial begin
        vec = 0;
        errs = 0;
        RST = 1'b1;
        AV = 1'b0; MV = 1'b0;
        AA = '0; AD = '0; MA = '0; MD = '0;
        test_reset();
        test_single();
        test_same_edge();
        test_tie_same_addr();
        test_same_addr();
        test_back_to_back();
        test_reset_mid();
        test_zero_reg();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
